register_bank_write_port: RTL and testbench
===========================================

REGISTER_BANK_WRITE_PORT -- requirements
Module: REGISTER_BANK_WRITE_PORT

Interface
REQ-001 The block SHALL have parameter BITS, default 32, giving the register word width.
REQ-002 The block SHALL have parameter ZERO_REG, default 1; when 1, register 0 is hardwired to zero.
REQ-003 The block SHALL have port CLK, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port RESET_N, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port WR_VALID, input, 1, write request present.
REQ-006 The block SHALL have port WR_READY, output, 1, block accepts the write this cycle.
REQ-007 The block SHALL have port WR_SELECT, input, 4, destination register index.
REQ-008 The block SHALL have port WR_DATA, input, BITS, write data.
REQ-009 The block SHALL have port CLEAR_REQ, input, 1, single-cycle pulse requesting a zero-fill of all 16 registers.
REQ-010 The block SHALL have port DATA, output, [15:0][BITS-1:0], packed register contents, word i = register i, feeding the read-side 16:1 select.
REQ-011 The block SHALL have port PENDING, output, 16, one-hot flag of the register whose write is staged but not committed.
REQ-012 The block SHALL have port BUSY, output, 1, high while in CLEAR state.

Function
REQ-013 A write SHALL be accepted in any cycle where WR_VALID and WR_READY are both high; WR_SELECT/WR_DATA are sampled into a staging register.
REQ-014 WR_READY SHALL be high in IDLE and low in CLEAR; it SHALL NOT depend combinationally on WR_VALID.
REQ-015 A staged write SHALL commit to DATA[WR_SELECT] on the next rising edge (write latency 2 edges from acceptance to DATA change).
REQ-016 Back-to-back accepted writes SHALL sustain one write per cycle; the staging register is overwritten as its previous content commits.
REQ-017 PENDING SHALL equal the one-hot decode of the staged index while the staging register is valid, else 16'h0000.
REQ-018 With ZERO_REG=1, writes to index 0 SHALL be accepted, SHALL drop at commit, DATA[0] SHALL read 0, and PENDING[0] SHALL stay 0.
REQ-019 The state machine SHALL have states IDLE and CLEAR; IDLE->CLEAR on CLEAR_REQ=1; CLEAR->IDLE after counter reaches 15.
REQ-020 In CLEAR a 4-bit counter SHALL start at 0 and zero register[counter] each cycle, incrementing; 16 cycles total.
REQ-021 CLEAR_REQ coincident with an accepted write SHALL let the write be staged and committed first; CLEAR then zeroes it.
REQ-022 A write staged on entry to CLEAR SHALL commit on the first CLEAR edge before any zeroing of that index takes effect.
REQ-023 CLEAR_REQ while already in CLEAR SHALL be ignored (counter not restarted).
REQ-024 Word widths SHALL be exactly BITS; no truncation or extension of WR_DATA.

Reset
REQ-025 RESET_N low SHALL asynchronously force: all 16 registers to 0, staging valid 0, PENDING 0, state IDLE, counter 0, BUSY 0.
REQ-026 WR_READY SHALL be 0 while RESET_N is low and 1 on the first edge after release.
REQ-027 Reset mid-CLEAR or with a write staged SHALL discard the operation; no partial commit after release.

Structure
REQ-028 The state enum (IDLE, CLEAR), register count 16, and index width 4 SHALL live in a shared datapath package.
REQ-029 One sub-module SHALL be natural: FOUR_TO_SIXTEEN_DECODER_MODULE (4-bit index -> 16-bit one-hot with enable), used for commit enables and PENDING.

Verification
REQ-030 Reset release, WR_VALID=1, WR_SELECT=5, WR_DATA=32'hDEADBEEF -> PENDING=16'h0020 next cycle, DATA[5]=32'hDEADBEEF one cycle later, all other words 0.
REQ-031 Three back-to-back writes to 1,2,3 with values 1,2,3 -> WR_READY stays high, DATA[1..3]=1,2,3 after 4 edges, PENDING sequence 0002,0004,0008,0000.
REQ-032 ZERO_REG=1, write 32'hFFFFFFFF to index 0 -> DATA[0]=0, PENDING=0 throughout.
REQ-033 All registers loaded with 32'hA5A5A5A5, pulse CLEAR_REQ -> BUSY high 16 cycles, WR_READY low, register k zero after cycle k, all zero at exit; second CLEAR_REQ mid-clear ignored.
REQ-034 Write index 9 staged, then RESET_N low for one cycle -> DATA[9]=0 and PENDING=0 after release.

Source files
------------

// File: rtl/register_bank_write_port_pkg.sv
// Shared datapath definitions for the 16-entry register bank write port.
package register_bank_write_port_pkg;
  localparam int NUM_REGS = 16;
  localparam int IDX_W    = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;
endpackage

// File: rtl/register_bank_write_port_four_to_sixteen_decoder.sv
// 4-bit index to 16-bit one-hot decode, all-zero when disabled.
module register_bank_write_port_four_to_sixteen_decoder
  import register_bank_write_port_pkg::*;
(
  input  logic                i_en,
  input  logic [IDX_W-1:0]    i_idx,
  output logic [NUM_REGS-1:0] o_onehot
);
  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_idx] = 1'b1;
  end
endmodule

// File: rtl/register_bank_write_port.sv
// Register bank write port: one-deep staged writes committing a cycle after
// acceptance, plus a sequential 16-cycle zero-fill.
//   state    | meaning
//   ST_IDLE  | accepting writes, staged write commits each edge
//   ST_CLEAR | zeroing register[r_cnt] each edge, writes refused
module register_bank_write_port
  import register_bank_write_port_pkg::*;
#(
  parameter int BITS     = 32,
  parameter int ZERO_REG = 1
) (
  input  logic                           CLK,
  input  logic                           RESET_N,
  input  logic                           WR_VALID,
  output logic                           WR_READY,
  input  logic [IDX_W-1:0]               WR_SELECT,
  input  logic [BITS-1:0]                WR_DATA,
  input  logic                           CLEAR_REQ,
  output logic [NUM_REGS-1:0][BITS-1:0]  DATA,
  output logic [NUM_REGS-1:0]            PENDING,
  output logic                           BUSY
);
  state_t                         r_state;
  logic [IDX_W-1:0]               r_cnt;
  logic                           r_ready;
  logic                           r_stg_valid;
  logic [IDX_W-1:0]               r_stg_idx;
  logic [BITS-1:0]                r_stg_data;
  logic [NUM_REGS-1:0][BITS-1:0]  r_regs;

  logic                           w_accept;
  logic                           w_stg_en;
  logic [NUM_REGS-1:0]            w_commit_oh;

  assign w_accept = WR_VALID & r_ready;
  // Staged writes to the hardwired register are dropped here, so register 0
  // never loads and its PENDING bit never rises.
  assign w_stg_en = r_stg_valid & ~((ZERO_REG != 0) && (r_stg_idx == '0));

  register_bank_write_port_four_to_sixteen_decoder u_commit_dec (
    .i_en     (w_stg_en),
    .i_idx    (r_stg_idx),
    .o_onehot (w_commit_oh)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_ready     <= 1'b0;
      r_stg_valid <= 1'b0;
      r_stg_idx   <= '0;
      r_stg_data  <= '0;
      r_regs      <= '0;
    end else begin
      r_stg_valid <= w_accept;
      if (w_accept) begin
        r_stg_idx  <= WR_SELECT;
        r_stg_data <= WR_DATA;
      end
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_commit_oh[i]) r_regs[i] <= r_stg_data;
      end
      // Zeroing is assigned after the commit so it wins on the same index.
      case (r_state)
        ST_IDLE: begin
          if (CLEAR_REQ) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_ready <= 1'b0;
          end else begin
            r_ready <= 1'b1;
          end
        end
        ST_CLEAR: begin
          r_regs[r_cnt] <= '0;
          if (r_cnt == LAST_IDX) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign WR_READY = r_ready;
  assign DATA     = r_regs;
  assign PENDING  = w_commit_oh;
  assign BUSY     = (r_state == ST_CLEAR);
endmodule

// File: tb/tb_register_bank_write_port.sv
// Scoreboard bench for register_bank_write_port: stimulus queues expected
// writes, a negedge monitor checks PENDING and the committed word.
module tb_register_bank_write_port;
  localparam int BITS     = 32;
  localparam int ZERO_REG = 1;

  logic                  CLK = 1'b0;
  logic                  RESET_N;
  logic                  WR_VALID;
  logic                  WR_READY;
  logic [3:0]            WR_SELECT;
  logic [BITS-1:0]       WR_DATA;
  logic                  CLEAR_REQ;
  logic [15:0][BITS-1:0] DATA;
  logic [15:0]           PENDING;
  logic                  BUSY;

  register_bank_write_port #(.BITS(BITS), .ZERO_REG(ZERO_REG)) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .WR_VALID  (WR_VALID),
    .WR_READY  (WR_READY),
    .WR_SELECT (WR_SELECT),
    .WR_DATA   (WR_DATA),
    .CLEAR_REQ (CLEAR_REQ),
    .DATA      (DATA),
    .PENDING   (PENDING),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  function automatic void chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  typedef struct packed {
    logic [3:0]      idx;
    logic [BITS-1:0] data;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  cur;
  logic hs_seen     = 1'b0;
  logic have_commit = 1'b0;

  always @(posedge CLK) hs_seen <= RESET_N && WR_VALID && WR_READY;

  always @(negedge CLK) begin
    logic [15:0]     exp_pend;
    logic [BITS-1:0] exp_word;
    if (!RESET_N) begin
      have_commit = 1'b0;
      exp_q.delete();
    end else begin
      if (have_commit) begin
        exp_word = (ZERO_REG != 0 && cur.idx == 4'd0) ? '0 : cur.data;
        chk($sformatf("commit_data[%0d]", cur.idx), DATA[cur.idx], exp_word);
        have_commit = 1'b0;
      end
      if (hs_seen) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_accept actual=accept expected=none");
        end else begin
          cur = exp_q.pop_front();
          exp_pend = '0;
          if (!(ZERO_REG != 0 && cur.idx == 4'd0)) exp_pend[cur.idx] = 1'b1;
          chk($sformatf("pending[%0d]", cur.idx), PENDING, exp_pend);
          have_commit = 1'b1;
        end
      end else begin
        chk("pending_idle", PENDING, 16'h0000);
      end
    end
  end

  task automatic do_write(input logic [3:0] idx, input logic [BITS-1:0] d);
    int guard = 0;
    WR_VALID  = 1'b1;
    WR_SELECT = idx;
    WR_DATA   = d;
    while (!WR_READY && guard < 100) begin
      @(negedge CLK);
      guard++;
    end
    if (!WR_READY) begin
      n_checks++;
      n_errors++;
      $display("FAIL write_ready_timeout actual=%0b expected=1", WR_READY);
      WR_VALID = 1'b0;
    end else begin
      exp_q.push_back('{idx: idx, data: d});
      @(negedge CLK);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0][BITS-1:0] exp_all;
    int guard;
    RESET_N   = 1'b0;
    WR_VALID  = 1'b0;
    WR_SELECT = '0;
    WR_DATA   = '0;
    CLEAR_REQ = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_ready", WR_READY, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_pending", PENDING, 16'h0000);
    chk("rst_data", DATA, '0);

    // Single write presented at reset release
    WR_VALID  = 1'b1;
    WR_SELECT = 4'd5;
    WR_DATA   = 32'hDEADBEEF;
    RESET_N   = 1'b1;
    #1 chk("ready_before_edge", WR_READY, 1'b0);
    @(negedge CLK);
    chk("ready_first_edge", WR_READY, 1'b1);
    do_write(4'd5, 32'hDEADBEEF);
    WR_VALID = 1'b0;
    @(negedge CLK);
    exp_all = '0;
    exp_all[5] = 32'hDEADBEEF;
    chk("single_write_all", DATA, exp_all);

    // Back-to-back writes
    do_write(4'd1, 32'd1);
    chk("b2b_ready1", WR_READY, 1'b1);
    do_write(4'd2, 32'd2);
    chk("b2b_ready2", WR_READY, 1'b1);
    do_write(4'd3, 32'd3);
    WR_VALID = 1'b0;
    @(negedge CLK);
    exp_all[1] = 32'd1;
    exp_all[2] = 32'd2;
    exp_all[3] = 32'd3;
    chk("b2b_all", DATA, exp_all);

    // Hardwired zero register
    do_write(4'd0, 32'hFFFFFFFF);
    WR_VALID = 1'b0;
    @(negedge CLK);
    chk("zero_reg_data", DATA[0], 32'h0);
    chk("zero_reg_pending", PENDING, 16'h0000);

    // Fill, then clear with a repeated request mid-clear
    for (int i = 0; i < 16; i++) do_write(4'(i), 32'hA5A5A5A5);
    WR_VALID = 1'b0;
    @(negedge CLK);
    chk("fill_last", DATA[15], 32'hA5A5A5A5);
    CLEAR_REQ = 1'b1;
    @(negedge CLK);
    CLEAR_REQ = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("clr_busy_%0d", k), BUSY, 1'b1);
      chk($sformatf("clr_ready_%0d", k), WR_READY, 1'b0);
      if (k >= 1) begin
        chk($sformatf("clr_zero_%0d", k - 1), DATA[k-1], 32'h0);
        chk($sformatf("clr_keep_%0d", k), DATA[k], 32'hA5A5A5A5);
      end
      if (k == 5) CLEAR_REQ = 1'b1;
      if (k == 6) CLEAR_REQ = 1'b0;
      @(negedge CLK);
    end
    chk("clr_exit_busy", BUSY, 1'b0);
    chk("clr_exit_ready", WR_READY, 1'b1);
    chk("clr_exit_data", DATA, '0);

    // Clear request coincident with an accepted write
    CLEAR_REQ = 1'b1;
    do_write(4'd7, 32'h12345678);
    CLEAR_REQ = 1'b0;
    WR_VALID  = 1'b0;
    chk("coinc_busy", BUSY, 1'b1);
    guard = 0;
    while (BUSY && guard < 40) begin
      @(negedge CLK);
      guard++;
    end
    chk("coinc_clear_done", BUSY, 1'b0);
    chk("coinc_zeroed", DATA[7], 32'h0);

    // Reset while a write is staged
    do_write(4'd9, 32'h99999999);
    WR_VALID = 1'b0;
    #2 RESET_N = 1'b0;
    @(negedge CLK);
    #2 RESET_N = 1'b1;
    @(negedge CLK);
    chk("rst_staged_data9", DATA[9], 32'h0);
    chk("rst_staged_pending", PENDING, 16'h0000);
    chk("rst_staged_all", DATA, '0);
    chk("rst_staged_ready", WR_READY, 1'b1);

    @(negedge CLK);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
